pet_needs_ctrl: RTL and testbench

Owns the pet's need registers (food, fun, rest, life) and serialises every update to them. It generates the needs-decay tick internally, accepts user action requests from the menu FSM, and arbitrates between the two so that exactly one update sequence touches the register set at a time. It sits between the top-level menu/button FSM, which issues actions, and the display path, which reads the values and status flags.

---
 rtl/pet_pkg.sv | 48 ++++
 rtl/sat_addsub.sv | 22 ++
 rtl/pet_needs_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_pet_needs_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared encodings, reset values and helpers for the pet need-register controller.
package pet_pkg;

  localparam int unsigned NEED_W = 7;

  localparam logic [NEED_W-1:0] NEED_MAX  = 7'd100;
  localparam logic [NEED_W-1:0] LIFE_INIT = 7'd100;
  localparam logic [NEED_W-1:0] NEED_INIT = 7'd50;

  typedef enum logic [1:0] {
    ACT_PLAY  = 2'd0,
    ACT_SLEEP = 2'd1,
    ACT_EAT   = 2'd2,
    ACT_HEAL  = 2'd3
  } act_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DECAY = 3'd1,
    ST_LIFE  = 3'd2,
    ST_ACT   = 3'd3,
    ST_DONE  = 3'd4,
    ST_DEAD  = 3'd5
  } state_e;

  typedef struct packed {
    logic [NEED_W-1:0] food;
    logic [NEED_W-1:0] fun;
    logic [NEED_W-1:0] rest;
    logic [NEED_W-1:0] life;
  } needs_t;

  // Net life change per tick: +1 per satisfied need, -1 per starved need.
  function automatic logic signed [7:0] life_delta(input needs_t n,
                                                   input logic [NEED_W-1:0] plus,
                                                   input logic [NEED_W-1:0] minus);
    logic signed [7:0] d;
    d = 8'sd0;
    if (n.food >= plus)  d = d + 8'sd1;
    if (n.food <= minus) d = d - 8'sd1;
    if (n.fun  >= plus)  d = d + 8'sd1;
    if (n.fun  <= minus) d = d - 8'sd1;
    if (n.rest >= plus)  d = d + 8'sd1;
    if (n.rest <= minus) d = d - 8'sd1;
    return d;
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// Saturating add/subtract of a need value, clamped to 0..NEED_MAX.
module sat_addsub
  import pet_pkg::*;
(
  input  logic [NEED_W-1:0] val,
  input  logic [NEED_W-1:0] step,
  input  logic              sub,
  output logic [NEED_W-1:0] res_c
);

  logic [NEED_W:0] sum;

  always_comb begin
    sum = {1'b0, val} + {1'b0, step};
    if (sub) begin
      res_c = (val < step) ? '0 : (val - step);
    end else begin
      res_c = (sum > {1'b0, NEED_MAX}) ? NEED_MAX : sum[NEED_W-1:0];
    end
  end

endmodule

// File: rtl/pet_needs_ctrl.sv
// Owns the pet need registers; serialises decay ticks and user actions onto them.
module pet_needs_ctrl
  import pet_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned FOOD_PERIOD = 3,
  parameter int unsigned FUN_PERIOD  = 4,
  parameter int unsigned REST_PERIOD = 5,
  parameter int unsigned LIFE_PLUS   = 70,
  parameter int unsigned LIFE_MINUS  = 30,
  parameter int unsigned DISEASE_TH  = 20,
  parameter int unsigned ACT_STEP    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              act_valid,
  input  logic [1:0]        act_code,
  output logic              act_ready,
  output logic              act_done,
  output logic              act_ok,
  output logic [NEED_W-1:0] food,
  output logic [NEED_W-1:0] fun,
  output logic [NEED_W-1:0] rest,
  output logic [NEED_W-1:0] life,
  output logic              disease,
  output logic              death,
  output logic              tick_done
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PER_W = 8;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pre_q, pre_d;
  logic              tick_pend_q, tick_pend_d;
  logic [PER_W-1:0]  food_cnt_q, food_cnt_d;
  logic [PER_W-1:0]  fun_cnt_q, fun_cnt_d;
  logic [PER_W-1:0]  rest_cnt_q, rest_cnt_d;
  needs_t            needs_q, needs_d;
  act_e              act_code_q, act_code_d;
  logic              act_ready_q, act_ready_d;
  logic              act_done_q, act_done_d;
  logic              act_ok_q, act_ok_d;
  logic              tick_done_q, tick_done_d;
  logic              disease_q, disease_d;
  logic              death_q, death_d;

  logic              pre_term;
  logic [PER_W-1:0]  food_cnt_nxt, fun_cnt_nxt, rest_cnt_nxt;
  logic              food_hit, fun_hit, rest_hit;
  logic signed [7:0] life_dlt;

  logic [NEED_W-1:0] food_step, fun_step, rest_step, life_step;
  logic              food_sub, fun_sub, rest_sub, life_sub;
  logic [NEED_W-1:0] food_res_c, fun_res_c, rest_res_c, life_res_c;

  assign pre_term     = (pre_q == CNT_W'(TICK_DIV - 1));
  assign food_cnt_nxt = food_cnt_q + PER_W'(1);
  assign fun_cnt_nxt  = fun_cnt_q + PER_W'(1);
  assign rest_cnt_nxt = rest_cnt_q + PER_W'(1);
  assign food_hit     = (food_cnt_nxt == PER_W'(FOOD_PERIOD));
  assign fun_hit      = (fun_cnt_nxt == PER_W'(FUN_PERIOD));
  assign rest_hit     = (rest_cnt_nxt == PER_W'(REST_PERIOD));
  assign life_dlt     = life_delta(needs_q, NEED_W'(LIFE_PLUS), NEED_W'(LIFE_MINUS));

  // Operand selection for the four saturating units, driven by the active sequence step.
  always_comb begin
    food_step = '0;
    fun_step  = '0;
    rest_step = '0;
    life_step = '0;
    food_sub  = 1'b0;
    fun_sub   = 1'b0;
    rest_sub  = 1'b0;
    life_sub  = 1'b0;
    case (state_q)
      ST_DECAY: begin
        food_step = {{(NEED_W-1){1'b0}}, food_hit};
        fun_step  = {{(NEED_W-1){1'b0}}, fun_hit};
        rest_step = {{(NEED_W-1){1'b0}}, rest_hit};
        food_sub  = 1'b1;
        fun_sub   = 1'b1;
        rest_sub  = 1'b1;
      end
      ST_LIFE: begin
        life_sub  = life_dlt[7];
        life_step = life_dlt[7] ? NEED_W'(-life_dlt) : NEED_W'(life_dlt);
      end
      ST_ACT: begin
        case (act_code_q)
          ACT_PLAY: begin
            fun_step  = NEED_W'(ACT_STEP);
            rest_step = NEED_W'(ACT_STEP / 2);
            rest_sub  = 1'b1;
          end
          ACT_SLEEP: rest_step = NEED_W'(ACT_STEP);
          ACT_EAT:   food_step = NEED_W'(ACT_STEP);
          ACT_HEAL: begin
            if (disease_q) life_step = NEED_W'(2 * ACT_STEP);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  sat_addsub u_food (.val(needs_q.food), .step(food_step), .sub(food_sub), .res_c(food_res_c));
  sat_addsub u_fun  (.val(needs_q.fun),  .step(fun_step),  .sub(fun_sub),  .res_c(fun_res_c));
  sat_addsub u_rest (.val(needs_q.rest), .step(rest_step), .sub(rest_sub), .res_c(rest_res_c));
  sat_addsub u_life (.val(needs_q.life), .step(life_step), .sub(life_sub), .res_c(life_res_c));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_term ? '0 : (pre_q + CNT_W'(1));
    tick_pend_d = tick_pend_q;
    food_cnt_d  = food_cnt_q;
    fun_cnt_d   = fun_cnt_q;
    rest_cnt_d  = rest_cnt_q;
    needs_d     = needs_q;
    act_code_d  = act_code_q;
    act_ready_d = 1'b0;
    act_done_d  = 1'b0;
    act_ok_d    = 1'b0;
    tick_done_d = 1'b0;
    disease_d   = disease_q;
    death_d     = death_q;

    case (state_q)
      ST_IDLE: begin
        if (tick_pend_q) begin
          tick_pend_d = 1'b0;
          state_d     = ST_DECAY;
        end else if (act_valid) begin
          act_ready_d = 1'b1;
          act_code_d  = act_e'(act_code);
          state_d     = ST_ACT;
        end
      end
      ST_DECAY: begin
        food_cnt_d   = food_hit ? '0 : food_cnt_nxt;
        fun_cnt_d    = fun_hit  ? '0 : fun_cnt_nxt;
        rest_cnt_d   = rest_hit ? '0 : rest_cnt_nxt;
        needs_d.food = food_res_c;
        needs_d.fun  = fun_res_c;
        needs_d.rest = rest_res_c;
        state_d      = ST_LIFE;
      end
      ST_LIFE: begin
        needs_d.life = life_res_c;
        tick_done_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_ACT: begin
        needs_d.food = food_res_c;
        needs_d.fun  = fun_res_c;
        needs_d.rest = rest_res_c;
        needs_d.life = life_res_c;
        act_done_d   = 1'b1;
        act_ok_d     = (act_code_q != ACT_HEAL) || disease_q;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        disease_d = (needs_q.life <= NEED_W'(DISEASE_TH));
        death_d   = (needs_q.life == '0);
        state_d   = (needs_q.life == '0) ? ST_DEAD : ST_IDLE;
      end
      ST_DEAD: begin
        // Frozen: every request is acknowledged then answered as rejected.
        death_d = 1'b1;
        if (act_ready_q) begin
          act_done_d = 1'b1;
        end else if (act_valid) begin
          act_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pre_term && (state_q != ST_DEAD)) tick_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      tick_pend_q  <= 1'b0;
      food_cnt_q   <= '0;
      fun_cnt_q    <= '0;
      rest_cnt_q   <= '0;
      needs_q.food <= NEED_INIT;
      needs_q.fun  <= NEED_INIT;
      needs_q.rest <= NEED_INIT;
      needs_q.life <= LIFE_INIT;
      act_code_q   <= ACT_PLAY;
      act_ready_q  <= 1'b0;
      act_done_q   <= 1'b0;
      act_ok_q     <= 1'b0;
      tick_done_q  <= 1'b0;
      disease_q    <= 1'b0;
      death_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      tick_pend_q  <= tick_pend_d;
      food_cnt_q   <= food_cnt_d;
      fun_cnt_q    <= fun_cnt_d;
      rest_cnt_q   <= rest_cnt_d;
      needs_q      <= needs_d;
      act_code_q   <= act_code_d;
      act_ready_q  <= act_ready_d;
      act_done_q   <= act_done_d;
      act_ok_q     <= act_ok_d;
      tick_done_q  <= tick_done_d;
      disease_q    <= disease_d;
      death_q      <= death_d;
    end
  end

  assign act_ready = act_ready_q;
  assign act_done  = act_done_q;
  assign act_ok    = act_ok_q;
  assign food      = needs_q.food;
  assign fun       = needs_q.fun;
  assign rest      = needs_q.rest;
  assign life      = needs_q.life;
  assign disease   = disease_q;
  assign death     = death_q;
  assign tick_done = tick_done_q;

endmodule

// File: tb/tb_pet_needs_ctrl.sv
// Randomised and directed bench for pet_needs_ctrl against a sequence-level reference model.
module tb_pet_needs_ctrl;
  import pet_pkg::*;

  localparam int TICK_DIV    = 8;
  localparam int FOOD_PERIOD = 3;
  localparam int FUN_PERIOD  = 4;
  localparam int REST_PERIOD = 5;
  localparam int LIFE_PLUS   = 70;
  localparam int LIFE_MINUS  = 30;
  localparam int DISEASE_TH  = 20;
  localparam int ACT_STEP    = 10;

  localparam int SEQ_NONE = 0;
  localparam int SEQ_TICK = 1;
  localparam int SEQ_ACT  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       act_valid = 1'b0;
  logic [1:0] act_code = 2'd0;
  logic       act_ready, act_done, act_ok, disease, death, tick_done;
  logic [6:0] food, fun, rest, life;

  pet_needs_ctrl #(
    .TICK_DIV(TICK_DIV), .FOOD_PERIOD(FOOD_PERIOD), .FUN_PERIOD(FUN_PERIOD),
    .REST_PERIOD(REST_PERIOD), .LIFE_PLUS(LIFE_PLUS), .LIFE_MINUS(LIFE_MINUS),
    .DISEASE_TH(DISEASE_TH), .ACT_STEP(ACT_STEP)
  ) dut (
    .clk(clk), .reset(reset), .act_valid(act_valid), .act_code(act_code),
    .act_ready(act_ready), .act_done(act_done), .act_ok(act_ok),
    .food(food), .fun(fun), .rest(rest), .life(life),
    .disease(disease), .death(death), .tick_done(tick_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_food, m_fun, m_rest, m_life, m_fc, m_uc, m_rc, m_pre, m_seq, m_age, m_code, m_tcount;
  bit m_pend, m_disease, m_death, m_in_dead, m_ready, m_done, m_ok, m_tdone;
  int snap_food, snap_fun, snap_rest, snap_life;
  bit req_active = 1'b0;
  logic [1:0] req_code = 2'd0;
  int dut_ticks = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 100) return 100;
    return v;
  endfunction

  task automatic model_step();
    bit was_ready;
    bit term;
    int nh, nl;
    if (reset) begin
      m_food = 50; m_fun = 50; m_rest = 50; m_life = 100;
      m_fc = 0; m_uc = 0; m_rc = 0; m_pre = 0; m_pend = 0;
      m_disease = 0; m_death = 0; m_in_dead = 0;
      m_ready = 0; m_done = 0; m_ok = 0; m_tdone = 0;
      m_seq = SEQ_NONE; m_age = 0; m_tcount = 0;
      req_active = 0;
      return;
    end
    was_ready = m_ready;
    m_ready = 0; m_done = 0; m_ok = 0; m_tdone = 0;
    term  = (m_pre == TICK_DIV - 1);
    m_pre = term ? 0 : m_pre + 1;
    if (m_in_dead) begin
      if (was_ready) m_done = 1;
      else if (act_valid) m_ready = 1;
    end else if (m_seq == SEQ_NONE) begin
      if (m_pend) begin
        m_pend = 0; m_seq = SEQ_TICK; m_age = 0;
      end else if (act_valid) begin
        m_ready = 1; m_seq = SEQ_ACT; m_age = 0; m_code = int'(act_code);
      end
    end else begin
      if (m_seq == SEQ_TICK && m_age == 0) begin
        m_fc++; m_uc++; m_rc++;
        if (m_fc == FOOD_PERIOD) begin m_fc = 0; m_food = clamp(m_food - 1); end
        if (m_uc == FUN_PERIOD)  begin m_uc = 0; m_fun  = clamp(m_fun - 1);  end
        if (m_rc == REST_PERIOD) begin m_rc = 0; m_rest = clamp(m_rest - 1); end
      end else if (m_seq == SEQ_TICK && m_age == 1) begin
        nh = int'(m_food >= LIFE_PLUS) + int'(m_fun >= LIFE_PLUS) + int'(m_rest >= LIFE_PLUS);
        nl = int'(m_food <= LIFE_MINUS) + int'(m_fun <= LIFE_MINUS) + int'(m_rest <= LIFE_MINUS);
        m_life = clamp(m_life + nh - nl);
        m_tdone = 1; m_tcount++;
      end else if (m_seq == SEQ_ACT && m_age == 0) begin
        m_done = 1; m_ok = 1;
        case (m_code)
          0: begin m_fun = clamp(m_fun + ACT_STEP); m_rest = clamp(m_rest - ACT_STEP / 2); end
          1: m_rest = clamp(m_rest + ACT_STEP);
          2: m_food = clamp(m_food + ACT_STEP);
          default: begin
            if (m_disease) m_life = clamp(m_life + 2 * ACT_STEP);
            else m_ok = 0;
          end
        endcase
      end else begin
        m_disease = (m_life <= DISEASE_TH);
        m_death   = (m_life == 0);
        m_in_dead = (m_life == 0);
        m_seq = SEQ_NONE;
      end
      m_age++;
    end
    if (term) m_pend = 1;
  endtask

  task automatic compare_all();
    check_eq("act_ready", int'(act_ready), int'(m_ready));
    check_eq("act_done",  int'(act_done),  int'(m_done));
    check_eq("act_ok",    int'(act_ok),    int'(m_ok));
    check_eq("tick_done", int'(tick_done), int'(m_tdone));
    check_eq("food",      int'(food),      m_food);
    check_eq("fun",       int'(fun),       m_fun);
    check_eq("rest",      int'(rest),      m_rest);
    check_eq("life",      int'(life),      m_life);
    check_eq("disease",   int'(disease),   int'(m_disease));
    check_eq("death",     int'(death),     int'(m_death));
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (tick_done === 1'b1) dut_ticks++;
    if (req_active && m_ready) req_active = 0;
    act_valid = req_active;
    act_code  = req_code;
    cyc++;
  endtask

  task automatic issue(input logic [1:0] code);
    req_active = 1;
    req_code   = code;
    act_valid  = 1'b1;
    act_code   = code;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    dut_ticks = 0;
  endtask

  task automatic do_action(input logic [1:0] code, output int ok);
    issue(code);
    for (int i = 0; i < 64; i++) begin
      step();
      if (m_ready) begin
        snap_food = m_food; snap_fun = m_fun; snap_rest = m_rest; snap_life = m_life;
      end
      if (m_done) break;
    end
    check_eq("act_done_seen", int'(act_done), 1);
    ok = int'(act_ok);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    int t_tick, t_ready, heal_exp;
    bit heal_a, heal_b;

    // Reset values and three idle ticks
    do_reset();
    do_reset();
    check_eq("rst_life", int'(life), 100);
    check_eq("rst_food", int'(food), 50);
    check_eq("rst_disease", int'(disease), 0);
    for (int i = 0; i < 100 && m_tcount < 3; i++) step();
    check_eq("tick3_food", int'(food), 49);
    check_eq("tick3_fun",  int'(fun),  50);
    check_eq("tick3_rest", int'(rest), 50);
    check_eq("tick3_life", int'(life), 100);
    check_eq("tick3_count", dut_ticks, 3);

    // EAT up to saturation
    for (int i = 0; i < 20 && m_food < 91; i++) do_action(ACT_EAT, ok);
    do_action(ACT_EAT, ok);
    check_eq("eat_sat_ok",   ok, 1);
    check_eq("eat_sat_food", int'(food), 100);
    check_eq("eat_sat_fun",  int'(fun),  snap_fun);
    check_eq("eat_sat_rest", int'(rest), snap_rest);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (!req_active && $urandom_range(0, 5) == 0) issue(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 399) == 0) begin
        act_valid = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end

    // Reset in the ACT cycle of a SLEEP request
    do_reset();
    issue(ACT_SLEEP);
    for (int i = 0; i < 20 && !m_ready; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_act_done", int'(act_done), 0);
    check_eq("rst_act_rest", int'(rest), 50);
    check_eq("rst_act_life", int'(life), 100);

    // Request raised in the cycle the tick becomes pending
    do_reset();
    for (int i = 0; i < 20 && !m_pend; i++) step();
    issue(ACT_EAT);
    t_tick = -1; t_ready = -100;
    for (int i = 0; i < 40 && !m_done; i++) begin
      step();
      if (tick_done === 1'b1 && t_tick < 0) t_tick = cyc;
      if (act_ready === 1'b1 && t_ready < 0) t_ready = cyc;
    end
    check_eq("collide_tick_seen", int'(t_tick > 0), 1);
    check_eq("collide_gap", t_ready - t_tick, 2);
    check_eq("collide_food", int'(food), 60);

    // Natural decline: HEAL without and with disease, then death
    do_reset();
    heal_a = 0; heal_b = 0;
    for (int i = 0; i < 4000 && !m_in_dead; i++) begin
      step();
      if (!heal_a && !m_disease && m_life <= 60 && m_life >= 40) begin
        do_action(ACT_HEAL, ok);
        check_eq("heal_nodis_ok", ok, 0);
        check_eq("heal_nodis_life", int'(life), snap_life);
        heal_a = 1;
      end else if (!heal_b && m_disease && m_life > 0) begin
        do_action(ACT_HEAL, ok);
        heal_exp = clamp(snap_life + 2 * ACT_STEP);
        check_eq("heal_dis_ok", ok, 1);
        check_eq("heal_dis_life", int'(life), heal_exp);
        check_eq("heal_dis_flag_at_done", int'(disease), 1);
        step();
        check_eq("heal_dis_flag_after", int'(disease), int'(heal_exp <= DISEASE_TH));
        heal_b = 1;
      end
    end
    check_eq("heal_paths_hit", int'(heal_a) + int'(heal_b), 2);
    check_eq("dead_life", int'(life), 0);
    check_eq("dead_flag", int'(death), 1);
    do_action(ACT_PLAY, ok);
    check_eq("dead_play_ok", ok, 0);
    check_eq("dead_play_fun", int'(fun), snap_fun);
    for (int i = 0; i < 40; i++) step();
    check_eq("dead_frozen_food", int'(food), snap_food);
    check_eq("dead_frozen_death", int'(death), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
